zeroriscy_multdiv_ctrl: RTL
===========================

// Module: zeroriscy_multdiv_ctrl
// PURPOSE
//  Sequencer between the ID/EX issue logic and zeroriscy_multdiv_fast.
//  - Accepts one MUL/MULH/DIV/REM request over a valid/ready handshake.
//  - Registers the operands and holds them stable for the whole operation.
//  - Drives mult_en/div_en until the unit reports ready, then captures the result.
//  - Buffers the result for a valid/ready consumer.
//  - Handles flush by draining the unit back to its idle state, so the next
//    operation always starts clean.
// PARAMETERS
//  none (operator encodings MD_OP_MULL/MULH/DIV/REM come from zeroriscy_defines)
// PORTS
//  clk                 in   1   clock, single clock domain
//  rst_n               in   1   asynchronous active-low reset
//  req_valid_i         in   1   request present
//  req_ready_o         out  1   request accepted this cycle when valid&ready
//  req_operator_i      in   2   MD_OP_MULL/MULH/DIV/REM
//  req_signed_mode_i   in   2   [0] op_a signed, [1] op_b signed
//  req_op_a_i          in   32  operand A
//  req_op_b_i          in   32  operand B
//  flush_i             in   1   kill in-flight or pending operation
//  md_mult_en_o        out  1   to multdiv mult_en_i
//  md_div_en_o         out  1   to multdiv div_en_i
//  md_operator_o       out  2   registered operator
//  md_signed_mode_o    out  2   registered signed mode
//  md_op_a_o           out  32  registered operand A
//  md_op_b_o           out  32  registered operand B
//  md_result_i         in   32  multdiv_result_o
//  md_ready_i          in   1   multdiv ready_o
//  rsp_valid_o         out  1   result held
//  rsp_ready_i         in   1   consumer takes result
//  rsp_result_o        out  32  captured result
//  busy_o              out  1   state != IDLE
// BEHAVIOUR
//  Reset values (all outputs):
//  - State IDLE; md_*_en_o=0; operand/operator/mode registers=0.
//  - rsp_valid_o=0; rsp_result_o=0; req_ready_o=1; busy_o=0.
//  State IDLE:
//  - req_ready_o = !flush_i.
//  - On accept: latch operator, mode and operands; go BUSY.
//  State BUSY:
//  - md_mult_en_o=1 if operator is MULL/MULH, else md_div_en_o=1 (never both).
//  - Enable stays high up to and including the md_ready_i cycle.
//  - md_ready_i & !flush_i: capture md_result_i into rsp_result_o; go RESP.
//  - flush_i & !md_ready_i: go DRAIN.
//  - flush_i & md_ready_i: discard the result; go IDLE.
//  State DRAIN:
//  - Same enable as BUSY. On md_ready_i: discard the result, go IDLE.
//  - flush_i in DRAIN: no effect.
//  State RESP:
//  - rsp_valid_o=1; rsp_result_o stable until handshake.
//  - rsp_ready_i & !flush_i: release the result.
//    - req_ready_o=1 this cycle; a same-cycle request is accepted (go BUSY), else go IDLE.
//  - flush_i: drop the result, go IDLE; req_ready_o=0.
//  Latency:
//  - Accept in cycle T; enable asserted from T+1.
//  - Unit latency L = enabled cycles up to and including md_ready_i:
//    MULL=3, MULH=4, DIV/REM=37, divide-by-zero=2.
//  - rsp_valid_o rises at T+L+1.
//  Rules:
//  - md_op_*/operator/mode change only on accept.
//  - md_ready_i outside BUSY/DRAIN is ignored.
//  - Reset mid-operation returns to IDLE; the multdiv unit shares rst_n.
// TESTING
//  - MULL a=7, b=6, signed=00, rsp_ready=1: md_mult_en_o high 3 cycles; rsp_valid at T+4, result 42.
//  - DIV a=-100, b=7, signed=11: md_div_en_o high 37 cycles; result 0xFFFFFFF2 (-14).
//  - REM a=5, b=0: md_div_en_o high 2 cycles; result 5. DIV a=5, b=0: result 0xFFFFFFFF.
//  - MULH issued, flush_i at 2nd enabled cycle: DRAIN; enable held until md_ready_i; no rsp_valid.
//    A following MULL 3*3 returns 9.
//  - Back-pressure: rsp_ready=0 for 5 cycles after MULL; result held, req_ready_o=0.
//    Release with a same-cycle new request: accepted in that cycle, no idle bubble.
//  - rst_n low during DIV COMP: all outputs at reset values; next DIV 20/3 returns 6.

Source files
------------

// File: rtl/zeroriscy_multdiv_ctrl_if.sv
// zeroriscy_multdiv_ctrl_if: request, multdiv-unit and response signals of the multdiv sequencer.
interface zeroriscy_multdiv_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_operator_i;
  logic [1:0]  req_signed_mode_i;
  logic [31:0] req_op_a_i;
  logic [31:0] req_op_b_i;
  logic        flush_i;
  logic        md_mult_en_o;
  logic        md_div_en_o;
  logic [1:0]  md_operator_o;
  logic [1:0]  md_signed_mode_o;
  logic [31:0] md_op_a_o;
  logic [31:0] md_op_b_o;
  logic [31:0] md_result_i;
  logic        md_ready_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic        busy_o;
  modport slave (
    input  req_valid_i, req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i, flush_i,
           md_result_i, md_ready_i, rsp_ready_i,
    output req_ready_o, md_mult_en_o, md_div_en_o, md_operator_o, md_signed_mode_o,
           md_op_a_o, md_op_b_o, rsp_valid_o, rsp_result_o, busy_o
  );
  modport master (
    output req_valid_i, req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i, flush_i,
           md_result_i, md_ready_i, rsp_ready_i,
    input  req_ready_o, md_mult_en_o, md_div_en_o, md_operator_o, md_signed_mode_o,
           md_op_a_o, md_op_b_o, rsp_valid_o, rsp_result_o, busy_o
  );
endinterface

// File: rtl/zeroriscy_multdiv_ctrl.sv
// zeroriscy_multdiv_ctrl: issues one mul/div to zeroriscy_multdiv_fast, buffers its result, drains on flush.
module zeroriscy_multdiv_ctrl (
  input  logic                           clk,
  input  logic                           rst_n,
  zeroriscy_multdiv_ctrl_if.slave        bus
);
  localparam logic [1:0] MD_OP_MULL = 2'b00;
  localparam logic [1:0] MD_OP_MULH = 2'b01;
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, RESP} state_t;
  state_t      r_state, w_next;
  logic [1:0]  r_operator, r_mode;
  logic [31:0] r_op_a, r_op_b, r_result;
  logic        w_accept, w_run, w_mult, w_capture;
  assign bus.req_ready_o = (r_state == IDLE || (r_state == RESP && bus.rsp_ready_i)) && !bus.flush_i;
  assign w_accept        = bus.req_valid_i && bus.req_ready_o;
  assign w_run           = r_state == BUSY || r_state == DRAIN;
  assign w_mult          = r_operator == MD_OP_MULL || r_operator == MD_OP_MULH;
  assign w_capture       = r_state == BUSY && bus.md_ready_i && !bus.flush_i;
  assign bus.md_mult_en_o     = w_run && w_mult;
  assign bus.md_div_en_o      = w_run && !w_mult;
  assign bus.md_operator_o    = r_operator;
  assign bus.md_signed_mode_o = r_mode;
  assign bus.md_op_a_o        = r_op_a;
  assign bus.md_op_b_o        = r_op_b;
  assign bus.rsp_valid_o      = r_state == RESP;
  assign bus.rsp_result_o     = r_result;
  assign bus.busy_o           = r_state != IDLE;
  // A flushed operation keeps its enable until the unit finishes so it returns to idle cleanly.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? BUSY : IDLE;
      BUSY:    w_next = bus.md_ready_i ? (bus.flush_i ? IDLE : RESP) : (bus.flush_i ? DRAIN : BUSY);
      DRAIN:   w_next = bus.md_ready_i ? IDLE : DRAIN;
      RESP:    w_next = bus.flush_i ? IDLE : bus.rsp_ready_i ? (w_accept ? BUSY : IDLE) : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_operator <= '0;
      r_mode     <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_result   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_operator <= bus.req_operator_i;
        r_mode     <= bus.req_signed_mode_i;
        r_op_a     <= bus.req_op_a_i;
        r_op_b     <= bus.req_op_b_i;
      end
      if (w_capture) r_result <= bus.md_result_i;
    end
  end
endmodule
